icache_refill_axi_bridge: RTL

//  Memory-side responder for icache line refills. Accepts one line-read request, issues one AXI4 INCR read burst,

---
 rtl/icache_refill_axi_bridge_pkg.sv | 14 +
 rtl/icache_refill_axi_bridge_refill_line_packer.sv | 47 ++++
 rtl/icache_refill_axi_bridge.sv | 113 +++++++++++
 3 files changed

// File: rtl/icache_refill_axi_bridge_pkg.sv
// icache_refill_axi_bridge_pkg: shared widths, AXI encodings and FSM states for the icache refill bridge
package icache_refill_axi_bridge_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int BEAT_WIDTH = 32;
    localparam int BEATS      = 8;
    localparam int LINE_WIDTH = BEAT_WIDTH * BEATS;
    localparam int CNT_WIDTH  = $clog2(BEATS);
    localparam int LINE_BYTES_LOG2 = $clog2(LINE_WIDTH / 8);
    localparam logic [3:0] AXI_ID         = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RET} state_e;
endpackage

// File: rtl/icache_refill_axi_bridge_refill_line_packer.sv
// refill_line_packer: counts accepted R beats, packs them into the line register and accumulates burst errors
module refill_line_packer
    import icache_refill_axi_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  beat_en_i,
    input  logic [BEAT_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    output logic [LINE_WIDTH-1:0] line_o,
    output logic                  err_o,
    output logic                  last_beat_o
);
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  err_q, err_d;
    assign last_beat_o = cnt_q == CNT_WIDTH'(BEATS - 1);
    assign line_o      = line_q;
    assign err_o       = err_q;
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        err_d  = err_q;
        if (clear_i) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (beat_en_i) begin
            line_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = rdata_i;
            // counter parks on the final slot; the FSM leaves R on that beat
            cnt_d = last_beat_o ? cnt_q : cnt_q + 1'b1;
            err_d = err_q | (rresp_i != AXI_RESP_OKAY) | (rlast_i != last_beat_o);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: rtl/icache_refill_axi_bridge.sv
// icache_refill_axi_bridge: turns one icache line-read request into one AXI4 INCR burst and returns the packed line
module icache_refill_axi_bridge
    import icache_refill_axi_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_mem_read_request,
    input  logic [ADDR_WIDTH-1:0] icache_mem_read_addr,
    input  logic                  read_data_from_mem_ok,
    output logic                  mem_ready_to_read,
    output logic                  mem_read_addr_ok,
    output logic                  mem_return_en,
    output logic [LINE_WIDTH-1:0] mem_return_data,
    output logic                  mem_return_err,
    output logic [3:0]            arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [BEAT_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  ready_q, ready_d, addr_ok_q, addr_ok_d, arvalid_q, arvalid_d;
    logic                  rready_q, rready_d, ret_en_q, ret_en_d;
    logic                  beat_fire, last_beat, ret_ack, unused_inputs;
    assign beat_fire     = rvalid & rready_q;
    assign ret_ack       = (state_q == ST_RET) & read_data_from_mem_ok;
    assign unused_inputs = ^{rid, icache_mem_read_addr[LINE_BYTES_LOG2-1:0]};
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ready_d   = ready_q;
        addr_ok_d = 1'b0;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ret_en_d  = ret_en_q;
        case (state_q)
            ST_IDLE: if (icache_mem_read_request) begin
                addr_d    = {icache_mem_read_addr[ADDR_WIDTH-1:LINE_BYTES_LOG2], {LINE_BYTES_LOG2{1'b0}}};
                addr_ok_d = 1'b1;
                arvalid_d = 1'b1;
                ready_d   = 1'b0;
                state_d   = ST_AR;
            end
            ST_AR: if (arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = ST_R;
            end
            // completion is decided by beat count alone; rlast only feeds the error flag
            ST_R: if (beat_fire && last_beat) begin
                rready_d = 1'b0;
                ret_en_d = 1'b1;
                state_d  = ST_RET;
            end
            ST_RET: if (read_data_from_mem_ok) begin
                ret_en_d = 1'b0;
                ready_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            ready_q   <= 1'b1;
            addr_ok_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ret_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ready_q   <= ready_d;
            addr_ok_q <= addr_ok_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ret_en_q  <= ret_en_d;
        end
    end
    refill_line_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (ret_ack),
        .beat_en_i   (beat_fire),
        .rdata_i     (rdata),
        .rresp_i     (rresp),
        .rlast_i     (rlast),
        .line_o      (mem_return_data),
        .err_o       (mem_return_err),
        .last_beat_o (last_beat)
    );
    assign mem_ready_to_read = ready_q;
    assign mem_read_addr_ok  = addr_ok_q;
    assign mem_return_en     = ret_en_q;
    assign arvalid           = arvalid_q;
    assign rready            = rready_q;
    assign araddr            = addr_q;
    assign arid              = AXI_ID;
    assign arlen             = arvalid_q ? 8'(BEATS - 1) : 8'd0;
    assign arsize            = arvalid_q ? AXI_SIZE_4B : 3'd0;
    assign arburst           = arvalid_q ? AXI_BURST_INCR : 2'd0;
endmodule
